// File: rtl/idma_read_port_merge.sv
// idma_read_port_merge: routes beats from the read port serving the head burst
// into a byte-rotated output stage with per-byte handshake.
module idma_read_port_merge #(
  parameter int NumPorts      = 2,
  parameter int StrbWidth     = 4,
  parameter int NumAxInFlight = 2,
  parameter int LenWidth      = 8
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [(NumPorts>1?$clog2(NumPorts):1)-1:0] ar_port_i,
  input  logic [LenWidth-1:0]                        ar_len_i,
  input  logic                                       ar_valid_i,
  output logic                                       ar_ready_o,
  input  logic [NumPorts*StrbWidth*8-1:0]            in_data_i,
  input  logic [NumPorts*StrbWidth-1:0]              in_strb_i,
  input  logic [NumPorts-1:0]                        in_last_i,
  input  logic [NumPorts-1:0]                        in_valid_i,
  output logic [NumPorts-1:0]                        in_ready_o,
  input  logic [$clog2(StrbWidth)-1:0]               shift_i,
  output logic [StrbWidth*8-1:0]                     out_data_o,
  output logic [StrbWidth-1:0]                       out_valid_o,
  input  logic [StrbWidth-1:0]                       out_ready_i,
  output logic                                       busy_o,
  output logic                                       err_o
);
  localparam int PW = NumPorts > 1 ? $clog2(NumPorts) : 1;
  localparam int DW = StrbWidth * 8;
  localparam int D  = NumAxInFlight;
  localparam int AW = D > 1 ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  logic [PW-1:0]        port_q [D];
  logic [LenWidth-1:0]  len_q [D];
  logic [AW-1:0]        rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0]        cnt_q;
  logic [LenWidth-1:0]  beat_cnt;
  logic [DW-1:0]        data_q, sel_data, rot_data;
  logic [StrbWidth-1:0] pend_q, sel_strb, rot_strb;
  logic [PW-1:0]        head_port;
  logic                 empty, full, push, pop, acc, load_ok, sel_last, err_q;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty      = cnt_q == '0;
  assign full       = cnt_q == CW'(D);
  assign push       = ar_valid_i & ~full;
  assign head_port  = port_q[rd_ptr];
  assign rd_nxt     = inc(rd_ptr);
  assign load_ok    = (pend_q & ~out_ready_i) == '0;
  assign acc        = |(in_valid_i & in_ready_o);
  assign pop        = acc & (beat_cnt == '0);
  assign ar_ready_o = ~full;
  assign out_data_o = data_q;
  assign out_valid_o = pend_q;
  assign busy_o     = ~empty | (pend_q != '0);
  assign err_o      = err_q;

  // a single-port instance serves every burst from port 0 whatever ar_port_i said
  always_comb begin
    in_ready_o = '0;
    sel_data   = '0;
    sel_strb   = '0;
    sel_last   = 1'b0;
    for (int p = 0; p < NumPorts; p++)
      if (NumPorts == 1 || int'(head_port) == p) begin
        in_ready_o[p] = ~empty & load_ok;
        sel_data      = in_data_i[p*DW +: DW];
        sel_strb      = in_strb_i[p*StrbWidth +: StrbWidth];
        sel_last      = in_last_i[p];
      end
  end

  always_comb begin
    rot_data = '0;
    rot_strb = '0;
    for (int b = 0; b < StrbWidth; b++) begin
      rot_data[b*8 +: 8] = sel_data[((b + int'(shift_i)) % StrbWidth)*8 +: 8];
      rot_strb[b]        = sel_strb[(b + int'(shift_i)) % StrbWidth];
    end
  end

  always_ff @(posedge clk_i)
    if (push) begin
      port_q[wr_ptr] <= ar_port_i;
      len_q[wr_ptr]  <= ar_len_i;
    end

  // on a pop the counter takes the next head's len; if the queue had one entry
  // that next head is the entry being pushed on this same edge
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt_q    <= '0;
      beat_cnt <= '0;
      data_q   <= '0;
      pend_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= rd_nxt;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (push & empty) beat_cnt <= ar_len_i;
      else if (acc) beat_cnt <= pop ? (cnt_q > CW'(1) ? len_q[rd_nxt] : push ? ar_len_i : '0) : beat_cnt - 1'b1;
      data_q <= acc ? rot_data : data_q;
      pend_q <= acc ? rot_strb : pend_q & ~out_ready_i;
      err_q  <= err_q | (acc & (sel_last != pop));
    end
endmodule

// File: doc/idma_read_port_merge.md
IDMA_READ_PORT_MERGE -- requirements
Module: idma_read_port_merge

Interface
REQ-001 SHALL have parameter NumPorts, default 2: number of read ports merged, valid range 1..8.
REQ-002 SHALL have parameter StrbWidth, default 4: bytes per beat, power of two, at least 2.
REQ-003 SHALL have parameter NumAxInFlight, default 2: route FIFO depth, at least 1.
REQ-004 SHALL have parameter LenWidth, default 8: AXI burst-length field width.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port clk_i  in  1  clock, all state on rising edge.
REQ-007 SHALL have port rst_i  in  1  asynchronous active-high reset.
REQ-008 SHALL have port ar_port_i  in  max(1,$clog2(NumPorts))  port that serves the issued burst.
REQ-009 SHALL have port ar_len_i  in  LenWidth  AXI len, i.e. beats minus one.
REQ-010 SHALL have ports ar_valid_i in 1 and ar_ready_o out 1  route-entry handshake.
REQ-011 SHALL have port in_data_i  in  NumPorts*StrbWidth*8  per-port beat data.
REQ-012 SHALL have port in_strb_i  in  NumPorts*StrbWidth  per-port byte enables.
REQ-013 SHALL have ports in_last_i in NumPorts, in_valid_i in NumPorts, in_ready_o out NumPorts  per-port beat handshake.
REQ-014 SHALL have port shift_i  in  $clog2(StrbWidth)  byte rotation amount.
REQ-015 SHALL have port out_data_o  out  StrbWidth*8  merged, rotated data.
REQ-016 SHALL have ports out_valid_o out StrbWidth and out_ready_i in StrbWidth  per-byte handshake to the dataflow element.
REQ-017 SHALL have port busy_o  out  1  route entries or bytes pending.
REQ-018 SHALL have port err_o  out  1  sticky protocol error.

Function
REQ-019 SHALL keep a route FIFO of NumAxInFlight {port, len} entries; ar_ready_o = not full; push on ar_valid_i & ar_ready_o; no push-through when full, even if a pop occurs in the same cycle.
REQ-020 SHALL hold a beat counter, loaded from the head entry's len when that entry becomes head, counting accepted beats toward zero.
REQ-021 SHALL hold an output stage: data register plus StrbWidth-bit pending mask.
REQ-022 SHALL define load_ok = (pending & ~out_ready_i) == 0.
REQ-023 SHALL drive in_ready_o[p] = FIFO non-empty & head port == p & load_ok; all other ports' ready low; a beat is accepted on in_valid_i[p] & in_ready_o[p].
REQ-024 SHALL, on accept, load data = ({d,d} >> shift_i*8) truncated to StrbWidth bytes and pending = strb rotated identically; shift_i is sampled only at accept.
REQ-025 SHALL, without accept, clear pending bits where out_ready_i is high; data register holds.
REQ-026 SHALL drive out_valid_o = pending and out_data_o = data register; input-to-output latency is exactly 1 cycle.
REQ-027 SHALL treat an all-zero strb beat as accepted and counted, leaving pending at zero.
REQ-028 SHALL, on accept with counter == 0, pop the FIFO and reload the counter from the new head in the same edge; if in_last_i[p] is low, set err_o.
REQ-029 SHALL, on accept with counter != 0, decrement the counter; if in_last_i[p] is high, set err_o; no pop.
REQ-030 SHALL not accept a beat in the cycle a push lands in an empty FIFO; in_ready_o derives only from registered state and out_ready_i.
REQ-031 SHALL keep err_o sticky, asserted the cycle after the offending accept, cleared only by reset; it does not stall data flow.
REQ-032 SHALL drive busy_o = FIFO non-empty | (pending != 0).
REQ-033 SHALL, with NumPorts = 1, ignore ar_port_i and behave identically with port 0.

Reset
REQ-034 SHALL, on rst_i high at any time (asynchronous), empty the FIFO and zero the counter, pending, data register and err_o; ar_ready_o = 1, in_ready_o = 0, out_valid_o = 0, busy_o = 0.
REQ-035 SHALL drop in-flight bursts and pending bytes on reset mid-operation, with no replay after reset release.

Verification
REQ-036 SHALL cover, with StrbWidth=4, NumPorts=2: push {port1,len0}; port1 beat 0x44332211, strb 0xF, last=1, shift 1 -> next cycle out_data_o 0x11443322, out_valid_o 0xF; FIFO pops; busy_o drops once all bytes are taken.
REQ-037 SHALL cover: push {0,len1} then {1,len0}; port1 valid early -> port1 stalled until port0 delivers 2 beats; port1 then accepted; err_o stays 0.
REQ-038 SHALL cover: pending 0xF, out_ready_i 0x3 then 0xC -> pending 0xC then 0x0; in_ready_o high in the second cycle, enabling a back-to-back load.
REQ-039 SHALL cover: {0,len2} with last on beat 2 of 3 -> err_o=1 the next cycle and remains 1; the third beat is still accepted.
REQ-040 SHALL cover: NumAxInFlight=2, three pushes -> third stalls with ar_ready_o=0 until first burst completes.
REQ-041 SHALL cover: rst_i asserted mid-burst with pending 0x5 -> immediately out_valid_o=0, busy_o=0, ar_ready_o=1.
